// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: owns the PC, reads imem over req/ack, holds instr for one EXEC; FETCH_PERF_CNT_EN adds retire/taken counters.
// Latency: one FETCH cycle (zero-wait ack) plus one EXEC cycle per instruction, minimum 2 cycles each.
// Backpressure: FETCH waits indefinitely for imem_ack; stall holds EXEC with pc/instr frozen.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic        jump,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [31:0] pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] taken_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] br_off;
  logic        load_instr;
  logic        exec_exit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_instr  = 1'b0;
    exec_exit   = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_instr = 1'b1;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        // branch/jump controls only matter on the cycle the instruction retires
        if (!stall) begin
          exec_exit = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign pc_plus4  = pc + 32'd4;
  assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign imem_addr = pc;
  assign OpCode    = instr[31:26];
  assign Funct     = instr[5:0];

  // jump wins over branch; every source keeps pc[1:0] at zero
  always_comb begin
    pc_nxt = pc_plus4;
    if (jump) begin
      pc_nxt = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (PCSrc) begin
      pc_nxt = pc_plus4 + br_off;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (exec_exit) begin
      pc <= pc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= 32'h0000_0000;
    end else if (load_instr) begin
      instr <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // both counters saturate instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= 32'h0000_0000;
      taken_cnt   <= 32'h0000_0000;
    end else if (exec_exit) begin
      if (retired_cnt != 32'hFFFF_FFFF) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if ((jump || PCSrc) && (taken_cnt != 32'hFFFF_FFFF)) begin
        taken_cnt <= taken_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, reset/perf sequences, then random traffic against a transaction model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        PCSrc;
  logic        jump;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [31:0] pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] taken_cnt;
`endif

  int nvec  = 0;
  int nfail = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .PCSrc      (PCSrc),
    .jump       (jump),
    .instr      (instr),
    .instr_valid(instr_valid),
    .OpCode     (OpCode),
    .Funct      (Funct),
    .pc_plus4   (pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt),
    .taken_cnt  (taken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        pcsrc;
    logic        jump;
    logic        req;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic a, input logic [31:0] rd, input logic s, input logic b, input logic j,
                     input logic er, input logic ev, input logic [31:0] ea, input logic [31:0] ei);
    vec_t v;
    v.ack = a; v.rdata = rd; v.stall = s; v.pcsrc = b; v.jump = j;
    v.req = er; v.valid = ev; v.addr = ea; v.ins = ei;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic er, input logic ev, input logic [31:0] ea, input logic [31:0] ei);
    logic [31:0] ep4;
    ep4 = ea + 32'd4;
    nvec++;
    if (imem_req !== er || instr_valid !== ev || imem_addr !== ea || instr !== ei ||
        OpCode !== ei[31:26] || Funct !== ei[5:0] || pc_plus4 !== ep4) begin
      nfail++;
      $display("FAIL %s: got req=%0b valid=%0b addr=%h instr=%h op=%h fn=%h pc4=%h; want req=%0b valid=%0b addr=%h instr=%h op=%h fn=%h pc4=%h",
               nm, imem_req, instr_valid, imem_addr, instr, OpCode, Funct, pc_plus4,
               er, ev, ea, ei, ei[31:26], ei[5:0], ep4);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Next PC straight from the ISA rules, using signed integer offsets.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins, input logic j, input logic b);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (b) begin
      off = int'($signed(ins[15:0])) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  logic [31:0] last_instr;

  task automatic exec_one(input logic [31:0] rd, input logic b, input logic j, input logic [31:0] ea);
    imem_ack = 1'b1; imem_rdata = rd; stall = 1'b0; PCSrc = 1'b0; jump = 1'b0;
    chk("perf_fetch", 1'b1, 1'b0, ea, last_instr);
    step();
    imem_ack = 1'b0; PCSrc = b; jump = j;
    chk("perf_exec", 1'b0, 1'b1, ea, rd);
    step();
    PCSrc = 1'b0; jump = 1'b0;
    last_instr = rd;
  endtask

  localparam logic [31:0] I_A  = 32'h0000_0020;
  localparam logic [31:0] I_B  = 32'h8C22_0004;
  localparam logic [31:0] I_BR = 32'h1000_FFFF;
  localparam logic [31:0] I_J  = 32'h0800_0040;
  localparam logic [31:0] I_S  = 32'h0123_4567;
  localparam logic [31:0] I_W  = 32'h1000_FFBD;

  // random-phase model state
  logic [31:0] m_pc, m_instr, m_ret, m_taken;
  logic        m_idle, m_exec, er;
  logic        r_ack, r_stall, r_b, r_j;
  logic [31:0] r_rd;

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0; PCSrc = 1'b0; jump = 1'b0;

    // ack, rdata, stall, PCSrc, jump | req, valid, addr, instr
    add(0, 32'h0, 0, 0, 0,  0, 0, 32'h0, 32'h0);
    add(1, I_A,   0, 1, 1,  1, 0, 32'h0, 32'h0);
    add(1, I_B,   0, 0, 0,  0, 1, 32'h0, I_A);
    add(0, 32'h0, 0, 1, 1,  1, 0, 32'h4, I_A);
    add(0, 32'h0, 0, 0, 0,  1, 0, 32'h4, I_A);
    add(0, 32'h0, 0, 0, 0,  1, 0, 32'h4, I_A);
    add(1, I_B,   0, 0, 0,  1, 0, 32'h4, I_A);
    add(0, 32'h0, 0, 0, 0,  0, 1, 32'h4, I_B);
    add(1, 32'h0, 0, 0, 0,  1, 0, 32'h8, I_B);
    add(0, 32'h0, 0, 0, 0,  0, 1, 32'h8, 32'h0);
    add(1, 32'h0, 0, 0, 0,  1, 0, 32'hC, 32'h0);
    add(0, 32'h0, 0, 0, 0,  0, 1, 32'hC, 32'h0);
    add(1, I_BR,  0, 0, 0,  1, 0, 32'h10, 32'h0);
    add(0, 32'h0, 0, 1, 0,  0, 1, 32'h10, I_BR);
    add(1, I_BR,  0, 0, 0,  1, 0, 32'h10, I_BR);
    add(0, 32'h0, 0, 0, 0,  0, 1, 32'h10, I_BR);
    add(1, 32'h0, 0, 0, 0,  1, 0, 32'h14, I_BR);
    add(0, 32'h0, 0, 0, 0,  0, 1, 32'h14, 32'h0);
    add(1, 32'h0, 0, 0, 0,  1, 0, 32'h18, 32'h0);
    add(0, 32'h0, 0, 0, 0,  0, 1, 32'h18, 32'h0);
    add(1, 32'h0, 0, 0, 0,  1, 0, 32'h1C, 32'h0);
    add(0, 32'h0, 0, 0, 0,  0, 1, 32'h1C, 32'h0);
    add(1, I_J,   0, 0, 0,  1, 0, 32'h20, 32'h0);
    add(0, 32'h0, 0, 1, 1,  0, 1, 32'h20, I_J);
    add(1, I_S,   0, 0, 0,  1, 0, 32'h100, I_J);
    add(1, 32'hFFFF_FFFF, 1, 1, 1,  0, 1, 32'h100, I_S);
    add(0, 32'h0, 1, 0, 1,  0, 1, 32'h100, I_S);
    add(0, 32'h0, 0, 0, 0,  0, 1, 32'h100, I_S);
    add(1, I_W,   0, 0, 0,  1, 0, 32'h104, I_S);
    add(0, 32'h0, 0, 1, 0,  0, 1, 32'h104, I_W);
    add(1, 32'h0, 0, 0, 0,  1, 0, 32'hFFFF_FFFC, I_W);
    add(0, 32'h0, 0, 0, 0,  0, 1, 32'hFFFF_FFFC, 32'h0);
    add(1, 32'h0, 0, 0, 0,  1, 0, 32'h0, 32'h0);
    add(0, 32'h0, 0, 0, 0,  0, 1, 32'h0, 32'h0);
    add(0, 32'h0, 0, 0, 0,  1, 0, 32'h4, 32'h0);

    step();
    chk("reset_state", 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b0;

    foreach (tbl[i]) begin
      imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata; stall = tbl[i].stall;
      PCSrc = tbl[i].pcsrc; jump = tbl[i].jump;
      chk($sformatf("vec%0d", i), tbl[i].req, tbl[i].valid, tbl[i].addr, tbl[i].ins);
      step();
    end

    // reset asserted in FETCH with an ack arriving the same cycle
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; PCSrc = 1'b0; jump = 1'b0; stall = 1'b0;
    chk("pre_rst_fetch", 1'b1, 1'b0, 32'h4, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_in_fetch", 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    chk("late_ack_idle", 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk32("retired_rst", retired_cnt, 32'd0);
    chk32("taken_rst", taken_cnt, 32'd0);
`endif
    step();
    imem_ack = 1'b0;
    chk("late_ack_ignored", 1'b1, 1'b0, 32'h0, 32'h0);

    last_instr = 32'h0;
    exec_one(I_A,          1'b0, 1'b0, 32'h0);
    exec_one(32'h1000_0001, 1'b1, 1'b0, 32'h4);
    exec_one(32'h0,        1'b0, 1'b0, 32'hC);
    exec_one(32'h0800_0000, 1'b0, 1'b1, 32'h10);
    exec_one(32'h0,        1'b0, 1'b0, 32'h0);
    chk("perf_after", 1'b1, 1'b0, 32'h4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk32("retired_5", retired_cnt, 32'd5);
    chk32("taken_2", taken_cnt, 32'd2);
`endif

    // randomized traffic against the transaction model
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_idle = 1'b1; m_exec = 1'b0; m_ret = 32'h0; m_taken = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      er = !m_idle && !m_exec;
      chk("rand", er, m_exec, m_pc, m_instr);
      r_ack   = ($urandom_range(0, 1) == 1);
      r_rd    = $urandom;
      r_stall = ($urandom_range(0, 2) == 0);
      r_b     = ($urandom_range(0, 1) == 1);
      r_j     = ($urandom_range(0, 3) == 0);
      imem_ack = r_ack; imem_rdata = r_rd; stall = r_stall; PCSrc = r_b; jump = r_j;
      if (m_idle) begin
        m_idle = 1'b0;
      end else if (er && r_ack) begin
        m_instr = r_rd;
        m_exec  = 1'b1;
      end else if (m_exec && !r_stall) begin
        m_pc    = ref_next(m_pc, m_instr, r_j, r_b);
        m_exec  = 1'b0;
        m_ret   = m_ret + 32'd1;
        if (r_j || r_b) m_taken = m_taken + 32'd1;
      end
      step();
    end
`ifdef FETCH_PERF_CNT_EN
    chk32("retired_rand", retired_cnt, m_ret);
    chk32("taken_rand", taken_cnt, m_taken);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
